// File: rtl/riscv_pkg.sv
// Shared encodings for the load/store datapath: access sizes and the
// store buffer occupancy state.
package riscv_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_R = 2'b11;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/store_lane_steer.sv
// Combinational lane steering for stores: replicates the right-aligned operand
// across byte lanes, builds byte enables and flags illegal alignments.
module store_lane_steer
    import riscv_pkg::*;
(
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    input  logic [31:0] data,
    output logic [31:0] wdata,
    output logic [3:0]  be,
    output logic        misaligned
);

    always_comb begin
        wdata      = data;
        be         = 4'b0000;
        misaligned = 1'b0;
        case (size)
            SIZE_B: begin
                wdata = {4{data[7:0]}};
                be    = 4'b0001 << addr;
            end
            SIZE_H: begin
                wdata      = {2{data[15:0]}};
                be         = addr[1] ? 4'b1100 : 4'b0011;
                misaligned = addr[0];
            end
            SIZE_W: begin
                be         = 4'b1111;
                misaligned = (addr != 2'b00);
            end
            // Reserved size is never legal; treat it like a misalignment.
            default: misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/store_write_unit.sv
// Store write path: one-entry buffer between execute and the data-memory
// write port, with misalignment rejection and a completed-store counter.
module store_write_unit
    import riscv_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_data,
    input  logic [1:0]            req_size,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [3:0]            mem_be,
    output logic                  misalign_err,
    output logic [ADDR_WIDTH-1:0] err_addr,
    output logic [CNT_WIDTH-1:0]  store_count,
    output state_t                dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; valid never waits on ready, and ready never looks at valid.

    state_t      state_q, state_d;
    logic [31:0] steer_wdata;
    logic [3:0]  steer_be;
    logic        steer_misaligned;
    logic        accept, load, reject, drain;

    store_lane_steer u_steer (
        .addr       (req_addr[1:0]),
        .size       (req_size),
        .data       (req_data),
        .wdata      (steer_wdata),
        .be         (steer_be),
        .misaligned (steer_misaligned)
    );

    assign mem_valid = (state_q == FULL);
    assign req_ready = (state_q == EMPTY) || mem_ready;
    assign accept    = req_valid && req_ready;
    assign load      = accept && !steer_misaligned;
    assign reject    = accept && steer_misaligned;
    assign drain     = mem_valid && mem_ready;
    assign dbg_state = state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= EMPTY;
        else       state_q <= state_d;
    end

    // A reload during drain keeps the buffer full; a reject never fills it.
    always_comb begin
        state_d = state_q;
        if (load)       state_d = FULL;
        else if (drain) state_d = EMPTY;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= 4'b0000;
        end else if (load) begin
            mem_addr  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
            mem_wdata <= steer_wdata;
            mem_be    <= steer_be;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            misalign_err <= 1'b0;
            err_addr     <= '0;
        end else begin
            misalign_err <= reject;
            if (reject) err_addr <= req_addr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)      store_count <= '0;
        else if (drain) store_count <= store_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end

endmodule

// File: tb/tb_store_write_unit.sv
// Scoreboard bench for store_write_unit: directed scenarios plus random
// traffic, checked against a transaction-level model of lane steering.
module tb_store_write_unit;
    import riscv_pkg::*;

    localparam int AW = 32;
    localparam int CW = 16;
    localparam int BW = AW + 36;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [AW-1:0] req_addr = '0;
    logic [31:0]   req_data = '0;
    logic [1:0]    req_size = 2'b00;
    logic          mem_valid;
    logic          mem_ready = 1'b1;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_be;
    logic          misalign_err;
    logic [AW-1:0] err_addr;
    logic [CW-1:0] store_count;
    state_t        dbg_state;

    store_write_unit #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_size     (req_size),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_be       (mem_be),
        .misalign_err (misalign_err),
        .err_addr     (err_addr),
        .store_count  (store_count),
        .dbg_state    (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    logic [BW-1:0] exp_q[$];
    logic [AW-1:0] err_q[$];
    time           err_due_q[$];
    int            checks = 0;
    int            errors = 0;
    logic          rand_ready = 1'b0;
    logic          mem_ready_dir = 1'b1;
    logic [CW-1:0] model_count = '0;
    logic          exp_full = 1'b0;
    logic          prev_stall = 1'b0;
    logic [BW-1:0] prev_beat = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference rules for a store request, computed arithmetically.
    function automatic logic bad_req(input logic [1:0] s, input logic [1:0] a);
        return (s == 2'b11) || (s == 2'b01 && a[0]) || (s == 2'b10 && a != 2'b00);
    endfunction

    function automatic logic [BW-1:0] expect_beat(input logic [AW-1:0] a, input logic [1:0] s,
                                                  input logic [31:0] d);
        logic [31:0] w;
        logic [3:0]  b;
        logic [AW-1:0] wa;
        int lane;
        lane = int'(a % 4);
        wa   = a - AW'(lane);
        case (s)
            2'b00: begin w = {24'b0, d[7:0]} * 32'h0101_0101; b = 4'(1 << lane); end
            2'b01: begin w = {16'b0, d[15:0]} * 32'h0001_0001; b = (lane >= 2) ? 4'hC : 4'h3; end
            default: begin w = d; b = 4'hF; end
        endcase
        return {wa, w, b};
    endfunction

    // ---------------- memory-side ready generator ----------------
    always @(posedge clk) begin
        #2;
        mem_ready = rand_ready ? ($urandom_range(0, 3) != 0) : mem_ready_dir;
    end

    // ---------------- driver tasks (called at posedge+1) ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [AW-1:0] a, input logic [1:0] s, input logic [31:0] d);
        bit done;
        done      = 1'b0;
        req_addr  = a;
        req_size  = s;
        req_data  = d;
        req_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (req_ready) begin
                if (bad_req(s, a[1:0])) begin
                    err_q.push_back(a);
                    err_due_q.push_back($time + 10);
                end else begin
                    exp_q.push_back(expect_beat(a, s, d));
                end
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got req_ready=0 for 200 cycles expected acceptance addr=%0h", a);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [BW-1:0] beat;
        logic          exp_err, exp_drain, acc_ok;
        beat = {mem_addr, mem_wdata, mem_be};
        if (reset) begin
            exp_q.delete();
            err_q.delete();
            err_due_q.delete();
            exp_full    = 1'b0;
            model_count = '0;
            prev_stall  = 1'b0;
        end else begin
            check("store_count", store_count, model_count);
            check("mem_valid", mem_valid, exp_full);
            check("dbg_state", dbg_state, exp_full ? FULL : EMPTY);
            check("req_ready", req_ready, !exp_full || mem_ready);
            if (prev_stall) check("stall_hold", beat, prev_beat);

            exp_err = (err_due_q.size() > 0) && (err_due_q[0] == $time);
            check("misalign_err", misalign_err, exp_err);
            if (exp_err) check("err_addr", err_addr, err_q[0]);
            if (err_due_q.size() > 0 && err_due_q[0] <= $time) begin
                void'(err_due_q.pop_front());
                void'(err_q.pop_front());
            end

            exp_drain = exp_full && mem_ready;
            if (mem_valid && mem_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mem_beat: got unexpected transfer %0h expected none", beat);
                end else begin
                    check("mem_beat", beat, exp_q.pop_front());
                end
            end
            if (exp_drain) model_count = model_count + 1'b1;

            acc_ok     = req_valid && (!exp_full || mem_ready) && !bad_req(req_size, req_addr[1:0]);
            exp_full   = acc_ok ? 1'b1 : (exp_drain ? 1'b0 : exp_full);
            prev_stall = mem_valid && !mem_ready;
            prev_beat  = beat;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        idle(2);
        reset = 1'b0;
        // Reset values, nothing has happened since release.
        check("rst_mem_valid", mem_valid, 1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_mem_be", mem_be, 4'h0);
        check("rst_err", misalign_err, 1'b0);
        check("rst_err_addr", err_addr, 32'h0);
        check("rst_count", store_count, 16'h0);
        check("rst_req_ready", req_ready, 1'b1);

        // Aligned mix with memory always ready.
        send(32'h100, SIZE_W, 32'hDEADBEEF);
        send(32'h102, SIZE_H, 32'h0000BEEF);
        send(32'h103, SIZE_B, 32'h000000EF);
        idle(3);
        check("mix_count", store_count, 16'd3);

        // Backpressure: second store waits five stalled cycles.
        mem_ready_dir = 1'b0;
        idle(1);
        send(32'h200, SIZE_W, 32'h11112222);
        fork
            send(32'h204, SIZE_W, 32'h33334444);
            begin
                idle(5);
                mem_ready_dir = 1'b1;
            end
        join
        idle(3);
        check("bp_count", store_count, 16'd5);

        // Misaligned and reserved-size requests.
        send(32'h101, SIZE_W, 32'hAAAA5555);
        send(32'h203, SIZE_H, 32'h00001234);
        send(32'h300, SIZE_R, 32'h0BADF00D);
        idle(3);
        check("mis_count", store_count, 16'd5);
        check("mis_err_addr", err_addr, 32'h300);

        // Drain and reject in the same cycle.
        mem_ready_dir = 1'b0;
        idle(1);
        send(32'h400, SIZE_W, 32'hCAFEF00D);
        mem_ready_dir = 1'b1;
        send(32'h001, SIZE_H, 32'h00005678);
        check("dr_mem_valid", mem_valid, 1'b0);
        idle(2);
        check("dr_count", store_count, 16'd6);
        check("dr_err_addr", err_addr, 32'h001);

        // Reset while a store is held stalled.
        mem_ready_dir = 1'b0;
        idle(1);
        send(32'h500, SIZE_W, 32'h55667788);
        idle(2);
        #2;
        reset = 1'b1;
        #1;
        check("rf_mem_valid", mem_valid, 1'b0);
        check("rf_mem_addr", mem_addr, 32'h0);
        check("rf_mem_wdata", mem_wdata, 32'h0);
        check("rf_mem_be", mem_be, 4'h0);
        check("rf_err", misalign_err, 1'b0);
        check("rf_err_addr", err_addr, 32'h0);
        check("rf_count", store_count, 16'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        mem_ready_dir = 1'b1;
        idle(5);
        check("rf_count_after", store_count, 16'h0);

        // Random traffic with random memory backpressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            send({$urandom_range(0, 255), 2'b00} | AW'($urandom_range(0, 3)),
                 2'($urandom_range(0, 3)), $urandom);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        rand_ready = 1'b0;
        mem_ready_dir = 1'b1;
        idle(5);

        // Counter wrap: 65535 stores from zero, then one more.
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        idle(1);
        for (int i = 0; i < 65535; i++) send(AW'(i * 4), SIZE_W, 32'(i));
        idle(3);
        check("wrap_full", store_count, 16'hFFFF);
        send(32'h40, SIZE_B, 32'h000000A5);
        idle(3);
        check("wrap_zero", store_count, 16'h0);

        check("exp_q_empty", exp_q.size(), 0);
        check("err_q_empty", err_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/store_write_unit.md
# store_write_unit

Store-side write path of the single-cycle core, the inverse of the writeback source select: it takes one 32-bit store operand and fans it out onto the four byte lanes of the data memory, with byte enables. It sits between the execute stage (SB/SH/SW) and the data-memory write port. A one-entry buffer with valid/ready handshakes on both sides lets the memory stall without losing a store. It also detects misaligned stores and counts completed writes.

## Interface
- ADDR_WIDTH, 32, byte-address width of `req_addr`, `mem_addr` and `err_addr`.
- CNT_WIDTH, 16, width of the completed-store counter.

Ports:
- `clk` in 1: single clock; all state is updated on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `req_valid` in 1: store request present.
- `req_ready` out 1: unit accepts the request this cycle.
- `req_addr` in ADDR_WIDTH: byte address.
- `req_data` in 32: store operand, right-aligned.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 reserved.
- `mem_valid` out 1: write transfer presented to memory.
- `mem_ready` in 1: memory accepts the transfer.
- `mem_addr` out ADDR_WIDTH: word address, bits [1:0] forced to 0.
- `mem_wdata` out 32: lane-steered data.
- `mem_be` out 4: byte enables; bit i enables bits [8i+7:8i].
- `misalign_err` out 1: one-cycle pulse for a rejected request.
- `err_addr` out ADDR_WIDTH: address of the most recent rejected request.
- `store_count` out CNT_WIDTH: number of completed memory transfers.

## Operation
- States: EMPTY (`mem_valid`=0) and FULL (`mem_valid`=1).
- `req_ready` = EMPTY OR (FULL AND `mem_ready`). It is combinational, with no dependence on `req_valid`.
- Accept = `req_valid` AND `req_ready`.

Lane steering on acceptance (`a` = `req_addr[1:0]`):
- Byte: `wdata` = {4{`req_data[7:0]`}}, `be` = 0001 << a.
- Half: `wdata` = {2{`req_data[15:0]`}}, `be` = `a[1]` ? 1100 : 0011. The request is misaligned if `a[0]`=1.
- Word: `wdata` = `req_data`, `be` = 1111. The request is misaligned if a ≠ 00.
- Size 11 is always rejected.

Valid request accepted:
- The buffer loads `mem_addr`/`mem_wdata`/`mem_be`.
- The next state is FULL.

Rejected request (misaligned or size 11):
- It is still consumed (handshake completes) and is never forwarded.
- `misalign_err` pulses the next cycle; `err_addr` loads `req_addr`.
- If FULL was draining in the same cycle, the next state is EMPTY.

Draining:
- FULL with `mem_ready`=1 completes the transfer and increments `store_count`, which wraps from all-ones to 0.
- A simultaneous valid accept reloads the buffer, so the state stays FULL.

Output stability:
- While FULL and `mem_ready`=0, `mem_addr`/`mem_wdata`/`mem_be` are held stable.
- An unconsumed request is ignored; it is never overwritten.

## Timing
- Latency: accept at edge N gives `mem_valid`=1 from edge N through at least the following cycle.
- Throughput: one store per cycle when `mem_ready` is held at 1 (back-to-back reload).
- `misalign_err` is high for exactly the cycle after the rejecting edge. Back-to-back rejects give back-to-back pulses.

Reset values (asynchronous):
- `mem_valid`=0, `mem_addr`=0, `mem_wdata`=0, `mem_be`=0000.
- `misalign_err`=0, `err_addr`=0, `store_count`=0.
- State is EMPTY, so `req_ready`=1 after reset.

Reset in mid-operation:
- Reset while FULL discards the held store.
- The discarded store is not counted and no error is raised.

## Structure
- Shared package `riscv_pkg`: size encodings `SIZE_B`=00, `SIZE_H`=01, `SIZE_W`=10, and the `state_t` enum {EMPTY, FULL}.
- One combinational sub-module, `store_lane_steer`:
  - Inputs: `addr[1:0]`, `size`, `data`.
  - Outputs: `wdata`, `be`, `misaligned`.
- The top level holds the buffer registers, the FSM, the error register and the counter.

## Test plan
- Aligned mix, `mem_ready`=1:
  - Stimulus: SW 0xDEADBEEF @0x100; SH 0xBEEF @0x102; SB 0xEF @0x103.
  - Required: `mem_be` 1111 / 1100 / 1000; `mem_wdata` 0xDEADBEEF / 0xBEEFBEEF / 0xEFEFEFEF; `mem_addr` 0x100 every time; `store_count`=3.
- Backpressure:
  - Stimulus: SW @0x200, then `mem_ready`=0 for 5 cycles, with a second SW presented throughout.
  - Required: `req_ready`=0 while stalled; outputs stable; the second store appears exactly one cycle after `mem_ready` rises.
- Misalignment:
  - Stimulus: SW @0x101; SH @0x203; size 11 @0x300.
  - Required: three `misalign_err` pulses; `err_addr` = 0x101, then 0x203, then 0x300; `mem_valid` never asserts; `store_count` unchanged.
- Simultaneous drain and reject:
  - Stimulus: FULL with `mem_ready`=1 while SH @0x001 is accepted.
  - Required: next state EMPTY, `store_count`+1, `misalign_err` pulse.
- Reset while FULL:
  - Stimulus: assert `reset` mid-stall.
  - Required: all outputs at their reset values immediately; `store_count`=0; the held store never appears.
- Counter wrap:
  - Stimulus: preload via 65535 stores with CNT_WIDTH=16, then one more.
  - Required: `store_count`=0.
